// File: rtl/conv_pkg.sv
// conv_pkg: pixel and 3x3 window types shared by the window generator and the convolution datapath
package conv_pkg;
    localparam int PIXEL_W       = 8;
    localparam int WINDOW_PIXELS = 9;
    localparam int WINDOW_W      = PIXEL_W * WINDOW_PIXELS;
    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [WINDOW_W-1:0] window_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-deep pixel delay that advances only when en is high
//   clk, rst_n : clock, asynchronous active-low reset (pointer only, storage is unreset)
//   en         : shift enable, one accepted pixel
//   din / dout : pixel in / pixel written DEPTH enables ago
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);
    localparam int AW = $clog2(DEPTH);
    pixel_t        mem [DEPTH];
    logic [AW-1:0] ptr;
    // circular buffer: the slot about to be overwritten holds the oldest pixel
    assign dout = mem[ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (en) ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    always_ff @(posedge clk)
        if (en) mem[ptr] <= din;
endmodule

// File: rtl/window_generator.sv
// window_generator: raster pixel stream to 3x3 windows (no padding) with a registered output stage
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous frame abort
//   in_pixel/valid/ready  : raster-order pixel input handshake
//   out_window/valid/ready: 72-bit window, row-major, top-left in the MSBs
//   frame_done            : flags the window of the frame's last pixel
module window_generator
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear,
    input  pixel_t  in_pixel,
    input  logic    in_valid,
    output logic    in_ready,
    output window_t out_window,
    output logic    out_valid,
    input  logic    out_ready,
    output logic    frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    pixel_t        tap1, tap2;
    pixel_t        c1 [3];
    pixel_t        c2 [3];
    logic          accept, col_last, row_last, qualify;
    window_t       win;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !clear;
    assign col_last = col == CW'(IMG_WIDTH - 1);
    assign row_last = row == RW'(IMG_HEIGHT - 1);
    assign qualify  = row >= RW'(2) && col >= CW'(2);
    // c2/c1 hold columns col-2/col-1; the third column is the live line-buffer taps and input pixel
    assign win = {c2[0], c1[0], tap2, c2[1], c1[1], tap1, c2[2], c1[2], in_pixel};
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_row1 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(in_pixel), .dout(tap1)
    );
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_row2 (
        .clk(clk), .rst_n(rst_n), .en(accept), .din(tap1), .dout(tap2)
    );
    always_ff @(posedge clk)
        if (accept) begin
            c2 <= c1;
            c1 <= '{tap2, tap1, in_pixel};
        end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                col <= col_last ? '0 : col + 1'b1;
                row <= col_last ? (row_last ? '0 : row + 1'b1) : row;
            end
            // accept implies the stage is free or draining, so a reload never drops a window
            if (accept && qualify) begin
                out_valid  <= 1'b1;
                out_window <= win;
                frame_done <= row_last && col_last;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator: random-stimulus bench for a 4x4 and an 8x6 window_generator against a frame-image model
module tb_window_generator;
    import conv_pkg::*;
    logic    clk = 0, rst_n = 0;
    logic    a_clear = 0, a_in_valid = 0, a_out_ready = 1, a_in_ready, a_out_valid, a_frame_done;
    logic    b_clear = 0, b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid, b_frame_done;
    pixel_t  a_in_pixel = 0, b_in_pixel = 0;
    window_t a_out_window, b_out_window;
    int      checks = 0, errors = 0;
    int      mw[2] = '{4, 8};
    int      mh[2] = '{4, 6};
    int      mr[2], mc[2], nwin[2], nfd[2];
    pixel_t  img[2][6][8];
    logic    pend[2], pfd[2], stall[2], hfd[2];
    window_t pw[2], hw[2];
    window_t loga[64];
    logic    logfd[64];
    always #5 clk = ~clk;
    window_generator #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_pixel(a_in_pixel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_window(a_out_window), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .frame_done(a_frame_done)
    );
    window_generator #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_pixel(b_in_pixel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_window(b_out_window), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .frame_done(b_frame_done)
    );
    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // model of one instance: stores the frame image and derives each window from it
    task automatic step(input int k, input logic clr, input logic iv, input logic ir, input pixel_t px,
                        input logic ov, input logic ordy, input logic fd, input window_t w);
        window_t win;
        if (!rst_n) begin
            pend[k] = 0; mr[k] = 0; mc[k] = 0; stall[k] = 0;
            check("reset_out_valid", ov, 0);
            return;
        end
        if (stall[k]) begin
            check("hold_window", w, hw[k]);
            check("hold_frame_done", fd, hfd[k]);
        end
        check("out_valid", ov, pend[k]);
        check("in_ready", ir, !ov || ordy);
        if (!ov) check("idle_frame_done", fd, 0);
        if (ov && ordy && pend[k]) begin
            check("window", w, pw[k]);
            check("frame_done", fd, pfd[k]);
            if (k == 0 && nwin[0] < 64) begin
                loga[nwin[0]] = w;
                logfd[nwin[0]] = fd;
            end
            nwin[k]++;
            if (fd) nfd[k]++;
            pend[k] = 0;
        end
        stall[k] = ov && !ordy;
        hw[k] = w;
        hfd[k] = fd;
        if (clr) begin
            pend[k] = 0; mr[k] = 0; mc[k] = 0; stall[k] = 0;
            return;
        end
        if (iv && ir) begin
            img[k][mr[k]][mc[k]] = px;
            if (mr[k] >= 2 && mc[k] >= 2) begin
                win = '0;
                for (int i = 0; i < 9; i++) win[71-8*i -: 8] = img[k][mr[k]-2+i/3][mc[k]-2+i%3];
                pend[k] = 1;
                pw[k] = win;
                pfd[k] = (mr[k] == mh[k] - 1) && (mc[k] == mw[k] - 1);
            end
            if (mc[k] == mw[k] - 1) begin
                mc[k] = 0;
                mr[k] = (mr[k] == mh[k] - 1) ? 0 : mr[k] + 1;
            end else mc[k]++;
        end
    endtask
    always @(negedge clk) begin
        step(0, a_clear, a_in_valid, a_in_ready, a_in_pixel, a_out_valid, a_out_ready, a_frame_done, a_out_window);
        step(1, b_clear, b_in_valid, b_in_ready, b_in_pixel, b_out_valid, b_out_ready, b_frame_done, b_out_window);
    end
    logic b_rand = 0;
    always @(posedge clk) begin
        #1;
        if (b_rand) b_out_ready = ($urandom_range(2) != 0);
    end
    task automatic drive(input int k, input logic v, input pixel_t p);
        if (k == 0) begin a_in_valid = v; a_in_pixel = p; end
        else begin b_in_valid = v; b_in_pixel = p; end
    endtask
    // send n pixels; seq gives pixel = index mod 16 (4*row+col on the 4x4 instance)
    task automatic send(input int k, input int n, input int gap_pct, input logic seq,
                        input pixel_t and_m, input pixel_t or_m);
        int   cyc = 0;
        logic v, acc;
        for (int i = 0; i < n;) begin
            v = $urandom_range(99) >= gap_pct;
            drive(k, v, seq ? pixel_t'(i % 16) : ((pixel_t'($urandom) & and_m) | or_m));
            @(negedge clk);
            acc = v && (k == 0 ? a_in_ready : b_in_ready);
            @(posedge clk);
            #1;
            if (acc) i++;
            if (++cyc > 5000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        drive(k, 0, 0);
    endtask
    task automatic drain();
        repeat (40) @(posedge clk);
        #1;
    endtask
    initial begin
        int n0, t;
        #1;
        repeat (3) @(negedge clk);
        check("reset_out_window", a_out_window, 0);
        check("reset_frame_done", a_frame_done, 0);
        check("reset_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        n0 = nwin[0];
        send(0, 16, 0, 1, 8'hff, 8'h00);
        drain();
        check("basic_count", nwin[0] - n0, 4);
        check("basic_first", loga[n0], 72'h00_01_02_04_05_06_08_09_0A);
        check("basic_last", loga[n0+3], 72'h05_06_07_09_0A_0B_0D_0E_0F);
        check("basic_last_fd", logfd[n0+3], 1);
        check("basic_first_fd", logfd[n0], 0);
        n0 = nwin[0];
        fork
            send(0, 16, 0, 1, 8'hff, 8'h00);
            begin
                t = 0;
                while (!a_out_valid && t < 200) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("stall_wait_timeout", t < 200, 1);
                @(posedge clk);
                #1;
                a_out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", a_in_ready, 0);
                    check("stall_out_valid", a_out_valid, 1);
                    @(posedge clk);
                    #1;
                end
                a_out_ready = 1;
            end
        join
        drain();
        check("stall_count", nwin[0] - n0, 4);
        send(0, 7, 20, 0, 8'hff, 8'h00);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        n0 = nwin[0];
        send(0, 16, 25, 0, 8'hff, 8'h00);
        drain();
        check("reset_frame_count", nwin[0] - n0, 4);
        n0 = nwin[0];
        t = nfd[0];
        send(0, 16, 0, 0, 8'h7f, 8'h00);
        send(0, 16, 0, 0, 8'hff, 8'h80);
        drain();
        check("b2b_count", nwin[0] - n0, 8);
        check("b2b_fd_count", nfd[0] - t, 2);
        check("b2b_fd4", logfd[n0+3], 1);
        check("b2b_fd8", logfd[n0+7], 1);
        check("b2b_fd5", logfd[n0+4], 0);
        send(0, 11, 0, 0, 8'hff, 8'h00);
        a_out_ready = 0;
        a_clear = 1;
        @(negedge clk);
        check("clear_pre_valid", a_out_valid, 1);
        @(posedge clk);
        #1;
        a_clear = 0;
        @(negedge clk);
        check("clear_drop_valid", a_out_valid, 0);
        @(posedge clk);
        #1;
        a_out_ready = 1;
        n0 = nwin[0];
        send(0, 16, 10, 0, 8'hff, 8'h00);
        drain();
        check("clear_frame_count", nwin[0] - n0, 4);
        n0 = nwin[1];
        b_rand = 1;
        send(1, 48, 30, 0, 8'hff, 8'h00);
        repeat (60) @(posedge clk);
        b_rand = 0;
        #2;
        b_out_ready = 1;
        drain();
        check("rand_count", nwin[1] - n0, 24);
        check("rand_fd_count", nfd[1], 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
